// File: rtl/wb_buffer_if.sv
// Writeback buffer bus: two result lanes in, register-file write port and
// two forwarding lookups out.
interface wb_buffer_if;
  logic        v0;
  logic [4:0]  rd0;
  logic [31:0] d0;
  logic        v1;
  logic [4:0]  rd1;
  logic [31:0] d1;
  logic        stall;
  logic        we;
  logic [4:0]  rw;
  logic [31:0] inW;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        fwdA_hit;
  logic [31:0] fwdA_data;
  logic        fwdB_hit;
  logic [31:0] fwdB_data;
  logic        ovf;

  // Upstream pipeline / register-file side
  modport master (
    output v0, rd0, d0, v1, rd1, d1, ra, rb,
    input  stall, we, rw, inW, fwdA_hit, fwdA_data, fwdB_hit, fwdB_data, ovf
  );

  // Buffer side
  modport slave (
    input  v0, rd0, d0, v1, rd1, d1, ra, rb,
    output stall, we, rw, inW, fwdA_hit, fwdA_data, fwdB_hit, fwdB_data, ovf
  );
endinterface

// File: rtl/wb_buffer.sv
// Dual-lane writeback buffer: in-order FIFO of pending register writes that
// drains one entry per cycle into the register file and forwards the
// youngest pending value for two read addresses.
module wb_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  wb_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [4:0]    mem_rd [DEPTH];
  logic [31:0]   mem_d  [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          ovf_q;

  logic push0;
  logic push1;
  logic pop;
  logic stall_c;

  // Stall depends on registered occupancy only; pushes are all-or-nothing
  assign stall_c = (CW'(DEPTH) - count) < CW'(2);
  assign push0   = bus.v0 && (bus.rd0 != 5'd0) && !stall_c;
  assign push1   = bus.v1 && (bus.rd1 != 5'd0) && !stall_c;
  assign pop     = (count != '0);

  assign bus.stall = stall_c;
  assign bus.we    = pop;
  assign bus.rw    = mem_rd[head];
  assign bus.inW   = mem_d[head];
  assign bus.ovf   = ovf_q;

  // Youngest stored entry matching addr; register 0 never matches
  function automatic logic [32:0] lookup(input logic [4:0] addr);
    logic [32:0]   r;
    logic [AW-1:0] idx;
    r = '0;
    for (int unsigned age = 0; age < DEPTH; age++) begin
      idx = head + AW'(age);
      if ((CW'(age) < count) && (mem_rd[idx] == addr) && (addr != 5'd0))
        r = {1'b1, mem_d[idx]};
    end
    return r;
  endfunction

  // Forwarding lookups over stored entries, including the head being written
  always_comb begin
    {bus.fwdA_hit, bus.fwdA_data} = lookup(bus.ra);
    {bus.fwdB_hit, bus.fwdB_data} = lookup(bus.rb);
  end

  // Pointer, occupancy and sticky overflow state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf_q <= 1'b0;
    end else begin
      head  <= head + AW'(pop);
      tail  <= tail + AW'(push0) + AW'(push1);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
      if (stall_c && (bus.v0 || bus.v1))
        ovf_q <= 1'b1;
    end
  end

  // Entry storage; lane 0 takes the lower slot when both lanes push
  always_ff @(posedge clk) begin
    if (push0) begin
      mem_rd[tail] <= bus.rd0;
      mem_d[tail]  <= bus.d0;
    end
    if (push1) begin
      mem_rd[AW'(tail + AW'(push0))] <= bus.rd1;
      mem_d[AW'(tail + AW'(push0))]  <= bus.d1;
    end
  end
endmodule

// File: tb/tb_wb_buffer.sv
// Testbench for wb_buffer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based model.
module tb_wb_buffer;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  logic clk;
  logic rst;
  wb_buffer_if bus ();

  wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  ent_t q[$];
  logic ovf_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                       input logic [4:0] ra, input logic [4:0] rb);
    bus.v0 = v0; bus.rd0 = rd0; bus.d0 = d0;
    bus.v1 = v1; bus.rd1 = rd1; bus.d1 = d1;
    bus.ra = ra; bus.rb = rb;
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, rb);
  endtask

  function automatic logic [32:0] model_fwd(input logic [4:0] a);
    logic [32:0] r;
    r = '0;
    if (a != 5'd0)
      foreach (q[i]) if (q[i].rd == a) r = {1'b1, q[i].d};
    return r;
  endfunction

  function automatic logic model_stall();
    return (DEPTH - q.size()) < 2;
  endfunction

  // Compare every observable output against the model
  task automatic model_compare();
    logic [32:0] fa;
    logic [32:0] fb;
    fa = model_fwd(bus.ra);
    fb = model_fwd(bus.rb);
    chk("we", 32'(bus.we), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("rw", 32'(bus.rw), 32'(q[0].rd));
      chk("inW", bus.inW, q[0].d);
    end
    chk("stall", 32'(bus.stall), 32'(model_stall()));
    chk("ovf", 32'(bus.ovf), 32'(ovf_m));
    chk("fwdA_hit", 32'(bus.fwdA_hit), 32'(fa[32]));
    chk("fwdA_data", bus.fwdA_data, fa[31:0]);
    chk("fwdB_hit", 32'(bus.fwdB_hit), 32'(fb[32]));
    chk("fwdB_data", bus.fwdB_data, fb[31:0]);
  endtask

  // Apply one rising edge to the model
  task automatic model_update();
    logic st;
    if (rst) begin
      q.delete();
      ovf_m = 1'b0;
      return;
    end
    st = model_stall();
    if (q.size() != 0) void'(q.pop_front());
    if (st) begin
      if (bus.v0 || bus.v1) ovf_m = 1'b1;
    end else begin
      if (bus.v0 && bus.rd0 != 5'd0) q.push_back('{bus.rd0, bus.d0});
      if (bus.v1 && bus.rd1 != 5'd0) q.push_back('{bus.rd1, bus.d1});
    end
  endtask

  // Check, advance one clock, and return to the falling edge
  task automatic tick();
    #1 model_compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    ovf_m = 1'b0;
    rst = 1'b1;
    idle(5'd0, 5'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_we", 32'(bus.we), 32'd0);
    chk("reset_stall", 32'(bus.stall), 32'd0);
    chk("reset_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single push
    drive(1'b1, 5'd10, 32'd2, 1'b0, 5'd0, 32'd0, 5'd10, 5'd0);
    #1 chk("single_no_bypass", 32'(bus.we), 32'd0);
    tick();
    idle(5'd10, 5'd0);
    #1;
    chk("single_we", 32'(bus.we), 32'd1);
    chk("single_rw", 32'(bus.rw), 32'd10);
    chk("single_inW", bus.inW, 32'd2);
    chk("single_fwd", bus.fwdA_data, 32'd2);
    tick();
    #1 chk("single_done", 32'(bus.we), 32'd0);
    tick();

    // Dual push, same destination
    drive(1'b1, 5'd5, 32'd4, 1'b1, 5'd5, 32'd16, 5'd5, 5'd5);
    tick();
    idle(5'd5, 5'd5);
    #1;
    chk("dual_rw0", 32'(bus.rw), 32'd5);
    chk("dual_inW0", bus.inW, 32'd4);
    chk("dual_fwd_both", bus.fwdA_data, 32'd16);
    tick();
    #1;
    chk("dual_inW1", bus.inW, 32'd16);
    chk("dual_fwd_one", bus.fwdA_data, 32'd16);
    tick();
    #1 chk("dual_done_hit", 32'(bus.fwdA_hit), 32'd0);
    tick();

    // Zero-register lane dropped
    drive(1'b1, 5'd0, 32'd7, 1'b1, 5'd11, 32'd16, 5'd0, 5'd11);
    tick();
    idle(5'd0, 5'd11);
    #1;
    chk("zero_rw", 32'(bus.rw), 32'd11);
    chk("zero_inW", bus.inW, 32'd16);
    chk("zero_ra_hit", 32'(bus.fwdA_hit), 32'd0);
    chk("zero_rb_hit", 32'(bus.fwdB_hit), 32'd1);
    tick();
    #1 chk("zero_single_write", 32'(bus.we), 32'd0);
    tick();

    // Fill to stall, dropped push, in-order drain
    drive(1'b1, 5'd1, 32'd100, 1'b1, 5'd2, 32'd200, 5'd3, 5'd4);
    tick();
    drive(1'b1, 5'd3, 32'd300, 1'b1, 5'd4, 32'd400, 5'd3, 5'd4);
    tick();
    drive(1'b1, 5'd5, 32'd500, 1'b0, 5'd0, 32'd0, 5'd5, 5'd4);
    #1;
    chk("fill_stall", 32'(bus.stall), 32'd1);
    chk("fill_rw_a", 32'(bus.rw), 32'd2);
    tick();
    idle(5'd5, 5'd4);
    #1;
    chk("fill_ovf", 32'(bus.ovf), 32'd1);
    chk("fill_rw_b", 32'(bus.rw), 32'd3);
    chk("fill_dropped", 32'(bus.fwdA_hit), 32'd0);
    tick();
    #1 chk("fill_rw_c", 32'(bus.rw), 32'd4);
    tick();
    #1 chk("fill_drained", 32'(bus.we), 32'd0);
    tick();

    // Asynchronous reset with three entries pending
    drive(1'b1, 5'd6, 32'd60, 1'b1, 5'd7, 32'd70, 5'd7, 5'd8);
    tick();
    drive(1'b1, 5'd8, 32'd80, 1'b1, 5'd9, 32'd90, 5'd7, 5'd8);
    tick();
    idle(5'd7, 5'd8);
    #1 chk("pre_rst_stall", 32'(bus.stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_we", 32'(bus.we), 32'd0);
    chk("arst_stall", 32'(bus.stall), 32'd0);
    chk("arst_hitA", 32'(bus.fwdA_hit), 32'd0);
    chk("arst_hitB", 32'(bus.fwdB_hit), 32'd0);
    chk("arst_ovf", 32'(bus.ovf), 32'd0);
    @(posedge clk);
    model_update();
    @(negedge clk);
    rst = 1'b0;
    tick();
    #1 chk("post_rst_no_write", 32'(bus.we), 32'd0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic       v0, v1;
      logic [4:0] rd0, rd1;
      v0  = ($urandom_range(0, 1) == 1);
      v1  = ($urandom_range(0, 2) == 0);
      rd0 = 5'($urandom_range(0, 7));
      rd1 = 5'($urandom_range(0, 7));
      if (model_stall()) begin
        if (rd0 == 5'd0) rd0 = 5'd1;
        if (rd1 == 5'd0) rd1 = 5'd2;
      end
      drive(v0, rd0, $urandom, v1, rd1, $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_buffer.md
WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of pending-writeback entries; power of two, at least 2.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 v0  input  1  lane-0 result valid (older lane).
REQ-005 rd0  input  5  lane-0 destination register.
REQ-006 d0  input  32  lane-0 result data.
REQ-007 v1  input  1  lane-1 result valid (younger lane).
REQ-008 rd1  input  5  lane-1 destination register.
REQ-009 d1  input  32  lane-1 result data.
REQ-010 stall  output  1  upstream must not present results; fewer than 2 free entries.
REQ-011 we  output  1  register-file write enable.
REQ-012 rw  output  5  register-file write address.
REQ-013 inW  output  32  register-file write data.
REQ-014 ra  input  5  forwarding lookup address A (same value driven to register file ra).
REQ-015 rb  input  5  forwarding lookup address B.
REQ-016 fwdA_hit  output  1  pending entry exists for ra.
REQ-017 fwdA_data  output  32  youngest pending data for ra.
REQ-018 fwdB_hit  output  1  pending entry exists for rb.
REQ-019 fwdB_data  output  32  youngest pending data for rb.
REQ-020 ovf  output  1  sticky: a push was attempted while stall=1.

Function
REQ-021 Storage: circular FIFO of DEPTH entries {rd[4:0], data[31:0]}, head/tail pointers, count 0..DEPTH.
REQ-022 Push: at rising edge, each lane with v=1 and rd!=0 is enqueued; lane 0 takes the lower FIFO position when both push.
REQ-023 Lanes with rd=0 are discarded silently and never consume an entry.
REQ-024 Pop: we = (count!=0); rw/inW driven combinationally from head entry; head popped at every rising edge where we=1.
REQ-025 Latency: result pushed at edge N appears on we/rw/inW after edge N if FIFO was empty, written into register file at edge N+1.
REQ-026 Simultaneous push(es) and pop in one cycle: count_next = count + pushes - pop; no bypass of the FIFO (empty FIFO with push still gives we=0 that cycle).
REQ-027 stall = (DEPTH - count) < 2, from registered count only (no combinational path from v0/v1).
REQ-028 When stall=1 all pushes that cycle are ignored (both lanes, even if one slot free) and ovf is set; ovf clears only on rst.
REQ-029 Pointers wrap modulo DEPTH; count never exceeds DEPTH nor underflows.
REQ-030 Forwarding: fwdX_hit=1 when any valid entry has rd==rX and rX!=0; fwdX_data = data of youngest matching entry (nearest tail); otherwise hit=0, data=0.
REQ-031 Forwarding searches only stored entries, including the head being written this cycle; same-cycle v0/v1 inputs are not searched.
REQ-032 Duplicate rd in FIFO is legal; entries drain in order so the register file ends with the youngest value.
REQ-033 When rw equals ra/rb on the write cycle, fwd output still hits with that entry's data (covers register-file read-during-write).

Reset
REQ-034 rst=1 asynchronously forces count=0, head=tail=0, ovf=0; hence we=0, stall=0, fwdA_hit=fwdB_hit=0 immediately without a clock edge.
REQ-035 Entry storage is not reset; pending entries are discarded by a mid-operation rst.
REQ-036 First push accepted at first rising edge after rst deasserts.

Verification
REQ-037 Single push: v0=1, rd0=10, d0=2 for one cycle -> next cycle we=1, rw=10, inW=2; following cycle we=0.
REQ-038 Dual push ordering: v0 rd0=5 d0=4, v1 rd1=5 d1=16 same edge -> writes rw=5/inW=4 then rw=5/inW=16 on consecutive cycles; fwdA_hit with ra=5 gives 16 while both pending, 16 while only the second is pending.
REQ-039 Zero-register drop: v0 rd0=0 d0=7, v1 rd1=11 d1=16 -> only one write, rw=11 inW=16; ra=0 never hits.
REQ-040 Fill/stall: DEPTH=4, dual pushes on 2 consecutive edges -> after second edge count=3, stall=1; a push presented while stall=1 is dropped and ovf=1; drain yields exactly 3 writes in order.
REQ-041 Async reset mid-operation: 3 pending entries, rst pulsed between edges -> we=0, stall=0, hits=0 before next edge; ovf=0; no stale writes after release.
